// File: rtl/ysyx_23060136_DEFINES.sv
// ============================================================================
// ysyx_23060136_DEFINES: shared types for the pipeline controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package ysyx_23060136_DEFINES;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    HALT       = 2'd2
  } ysyx_23060136_pipe_state_t;

  // Anything other than HALT still accepts redirects and counts events.
  function automatic logic pipe_state_live(input ysyx_23060136_pipe_state_t st);
    return st != HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060136_perf_cnt.sv
// ============================================================================
// ysyx_23060136_perf_cnt: wrapping event counter with enable, async reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060136_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060136_pipe_ctrl.sv
// ============================================================================
// ysyx_23060136_pipe_ctrl: stall/flush arbitration, redirect FSM, perf counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060136_pipe_ctrl
  import ysyx_23060136_DEFINES::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_i_valid,
  input  logic             EX_i_busy,
  input  logic             EX_i_redirect,
  input  logic             ID_i_load_use,
  input  logic             ME_i_busy,
  input  logic             WB_i_system_halt,
  output logic             FORWARD_stallIF,
  output logic             FORWARD_stallID,
  output logic             FORWARD_stallEX,
  output logic             FORWARD_stallME,
  output logic             FORWARD_stallWB,
  output logic             FORWARD_flushIF,
  output logic             FORWARD_flushID,
  output logic             FORWARD_flushEX,
  output logic             FORWARD_flushME,
  output logic [CNT_W-1:0] PERF_o_stall_cnt,
  output logic [CNT_W-1:0] PERF_o_redirect_cnt
);

  ysyx_23060136_pipe_state_t state_q;

  logic w_back_busy;
  logic w_ex_busy;
  logic w_load_use;
  logic w_redirect;
  logic w_redir_acc;
  logic w_stall_en;

  // A busy MEM or EX stage masks the younger hazard sources entirely.
  assign w_back_busy = ME_i_busy | EX_i_busy;
  assign w_ex_busy   = EX_i_busy & ~ME_i_busy;
  assign w_load_use  = ID_i_load_use & ~w_back_busy;
  assign w_redirect  = EX_i_redirect & ~w_back_busy;
  assign w_redir_acc = w_redirect & pipe_state_live(state_q);

  always_comb begin
    FORWARD_stallIF = 1'b0;
    FORWARD_stallID = 1'b0;
    FORWARD_stallEX = 1'b0;
    FORWARD_stallME = 1'b0;
    FORWARD_stallWB = 1'b0;
    FORWARD_flushIF = 1'b0;
    FORWARD_flushID = 1'b0;
    FORWARD_flushEX = 1'b0;
    FORWARD_flushME = 1'b0;
    if (rst) begin
      FORWARD_flushIF = 1'b1;
      FORWARD_flushID = 1'b1;
      FORWARD_flushEX = 1'b1;
      FORWARD_flushME = 1'b1;
    end else if (state_q == HALT) begin
      FORWARD_stallIF = 1'b1;
      FORWARD_stallID = 1'b1;
      FORWARD_stallEX = 1'b1;
      FORWARD_stallME = 1'b1;
      FORWARD_stallWB = 1'b1;
    end else begin
      if (ME_i_busy) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_stallEX = 1'b1;
        FORWARD_stallME = 1'b1;
        FORWARD_flushME = 1'b1;
      end
      if (w_ex_busy) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_stallEX = 1'b1;
        FORWARD_flushEX = 1'b1;
      end
      if (w_load_use) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_stallID = 1'b1;
        FORWARD_flushID = 1'b1;
      end
      // Redirect kills the ID instruction even if load-use wanted to hold it.
      if (w_redirect) begin
        FORWARD_flushIF = 1'b1;
        FORWARD_flushID = 1'b1;
        FORWARD_stallID = 1'b0;
      end
      if (~IF_i_valid & ~w_back_busy & ~w_load_use) begin
        FORWARD_stallIF = 1'b1;
        FORWARD_flushIF = 1'b1;
      end
      if (state_q == REDIR_WAIT) begin
        FORWARD_stallIF = 1'b0;
        FORWARD_flushIF = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (WB_i_system_halt)                state_q <= HALT;
          else if (w_redir_acc & ~IF_i_valid)  state_q <= REDIR_WAIT;
        end
        REDIR_WAIT: begin
          if (WB_i_system_halt)                state_q <= HALT;
          else if (w_redir_acc)                state_q <= REDIR_WAIT;
          else if (IF_i_valid)                 state_q <= RUN;
        end
        HALT:    state_q <= HALT;
        default: state_q <= RUN;
      endcase
    end
  end

  assign w_stall_en = FORWARD_stallIF & pipe_state_live(state_q);

  ysyx_23060136_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_stall_en),
    .cnt_o (PERF_o_stall_cnt)
  );

  ysyx_23060136_perf_cnt #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_redir_acc),
    .cnt_o (PERF_o_redirect_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060136_pipe_ctrl.sv
// ============================================================================
// tb_ysyx_23060136_pipe_ctrl: directed stimulus, reference model, literal pins.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060136_pipe_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, ifv, exb, exr, lu, meb, hlt;
  logic sIF, sID, sEX, sME, sWB, fIF, fID, fEX, fME;
  logic [CW-1:0] scnt, rcnt;

  int n_cmp = 0;
  int n_fail = 0;

  ysyx_23060136_pipe_ctrl #(.CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .IF_i_valid          (ifv),
    .EX_i_busy           (exb),
    .EX_i_redirect       (exr),
    .ID_i_load_use       (lu),
    .ME_i_busy           (meb),
    .WB_i_system_halt    (hlt),
    .FORWARD_stallIF     (sIF),
    .FORWARD_stallID     (sID),
    .FORWARD_stallEX     (sEX),
    .FORWARD_stallME     (sME),
    .FORWARD_stallWB     (sWB),
    .FORWARD_flushIF     (fIF),
    .FORWARD_flushID     (fID),
    .FORWARD_flushEX     (fEX),
    .FORWARD_flushME     (fME),
    .PERF_o_stall_cnt    (scnt),
    .PERF_o_redirect_cnt (rcnt)
  );

  always #5 clk = ~clk;

  // {stallIF,ID,EX,ME,WB, flushIF,ID,EX,ME}
  wire [8:0] act = {sIF, sID, sEX, sME, sWB, fIF, fID, fEX, fME};

  // Model state: mode 0 = running, 1 = waiting out stale fetch, 2 = halted.
  int m_mode = 0;
  int m_sc = 0;
  int m_rc = 0;

  function automatic logic [8:0] model_out();
    int depth;
    bit [4:0] st;
    bit [3:0] fl;
    bit blocked;
    if (rst) return 9'b00000_1111;
    if (m_mode == 2) return 9'b11111_0000;
    depth = 0; fl = '0; blocked = meb || exb;
    if (meb)      begin depth = 4; fl[3] = 1'b1; end
    else if (exb) begin depth = 3; fl[2] = 1'b1; end
    else begin
      if (lu)  begin depth = 2; fl[1] = 1'b1; end
      if (exr) begin fl[0] = 1'b1; fl[1] = 1'b1; end
      if (!ifv && depth == 0) begin depth = 1; fl[0] = 1'b1; end
    end
    st = '0;
    for (int k = 0; k < 5; k++) st[k] = (k < depth);
    if (exr && !blocked) st[1] = 1'b0;
    if (m_mode == 1) begin st[0] = 1'b0; fl[0] = 1'b1; end
    return {st[0], st[1], st[2], st[3], st[4], fl[0], fl[1], fl[2], fl[3]};
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    bit acc;
    if (rst) begin m_mode = 0; m_sc = 0; m_rc = 0; end
    e = model_out();
    n_cmp++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL ctrl_vec t=%0t got=%b want=%b", $time, act, e);
    end
    n_cmp++;
    if (scnt !== CW'(m_sc)) begin
      n_fail++;
      $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, scnt, m_sc);
    end
    n_cmp++;
    if (rcnt !== CW'(m_rc)) begin
      n_fail++;
      $display("FAIL redirect_cnt t=%0t got=%0d want=%0d", $time, rcnt, m_rc);
    end
    if (!rst && m_mode != 2) begin
      acc = exr && !meb && !exb;
      if (e[8]) m_sc = (m_sc + 1) % (1 << CW);
      if (acc)  m_rc = (m_rc + 1) % (1 << CW);
      if (hlt)                        m_mode = 2;
      else if (m_mode == 0 && acc && !ifv) m_mode = 1;
      else if (m_mode == 1 && !acc && ifv) m_mode = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ifv = 1'b1; exb = 1'b0; exr = 1'b0; lu = 1'b0; meb = 1'b0; hlt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_idle_vec", 32'(act), 32'h000);
    chk("reset_stall_cnt", 32'(scnt), 0);
    chk("reset_redir_cnt", 32'(rcnt), 0);

    // MEM busy holds back a redirect for 4 cycles
    tick(); meb = 1'b1; exr = 1'b1;
    @(negedge clk);
    chk("me_busy_vec", 32'(act), 32'(9'b11110_0001));
    chk("me_busy_redir_cnt", 32'(rcnt), 0);
    repeat (3) tick();
    tick(); meb = 1'b0;
    @(negedge clk);
    chk("redir_after_me_vec", 32'(act), 32'(9'b00000_1100));
    chk("me_stall_cnt", 32'(scnt), 4);
    tick(); exr = 1'b0;
    @(negedge clk);
    chk("me_redir_cnt", 32'(rcnt), 1);

    // single-cycle load-use
    tick(); lu = 1'b1;
    @(negedge clk);
    chk("load_use_vec", 32'(act), 32'(9'b11000_0100));
    tick(); lu = 1'b0;
    @(negedge clk);
    chk("load_use_gone_vec", 32'(act), 32'h000);

    // redirect during in-flight fetch
    tick(); exr = 1'b1; ifv = 1'b0;
    @(negedge clk);
    chk("redir_miss_vec", 32'(act), 32'(9'b10000_1100));
    tick(); exr = 1'b0;
    @(negedge clk);
    chk("redir_wait_vec", 32'(act), 32'(9'b00000_1000));
    tick();
    tick(); ifv = 1'b1;
    @(negedge clk);
    chk("stale_resp_vec", 32'(act), 32'(9'b00000_1000));
    tick();
    @(negedge clk);
    chk("back_to_run_vec", 32'(act), 32'h000);
    chk("mid_stall_cnt", 32'(scnt), 6);
    chk("mid_redir_cnt", 32'(rcnt), 2);

    // back-to-back redirects
    tick(); exr = 1'b1;
    tick();
    tick(); exr = 1'b0;
    @(negedge clk);
    chk("b2b_redir_cnt", 32'(rcnt), 4);

    // halt together with a redirect, then hazards while halted
    tick(); hlt = 1'b1; exr = 1'b1;
    @(negedge clk);
    chk("halt_cycle_vec", 32'(act), 32'(9'b00000_1100));
    tick(); hlt = 1'b0; meb = 1'b1;
    @(negedge clk);
    chk("halted_vec", 32'(act), 32'(9'b11111_0000));
    chk("halt_redir_cnt", 32'(rcnt), 5);
    tick(); meb = 1'b0; exb = 1'b1; ifv = 1'b0;
    tick(); exb = 1'b0; lu = 1'b1;
    tick(); lu = 1'b0; exr = 1'b0;
    @(negedge clk);
    chk("halted_vec2", 32'(act), 32'(9'b11111_0000));
    chk("halt_stall_frozen", 32'(scnt), 6);
    chk("halt_redir_frozen", 32'(rcnt), 5);

    // counter wrap at 4 bits, then reset mid-stall
    tick(); rst = 1'b1; ifv = 1'b1;
    tick(); rst = 1'b0; exb = 1'b1;
    repeat (16) tick();
    tick();
    @(negedge clk);
    chk("wrap_stall_cnt", 32'(scnt), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_stall_cnt", 32'(scnt), 0);
    chk("rst_mid_redir_cnt", 32'(rcnt), 0);
    chk("rst_mid_vec", 32'(act), 32'(9'b00000_1111));
    tick(); rst = 1'b0; exb = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("post_rst_idle_vec", 32'(act), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_23060136_pipe_ctrl.md
# ysyx_23060136_pipe_ctrl

Central pipeline controller for the five-stage core (IF, ID, EX, MEM, WB). It produces every `FORWARD_stall*` and `FORWARD_flush*` signal consumed by the PC register and the four segment registers (IF_ID, ID_EX, EX_MEM, MEM_WB). The inputs it resolves are cache waits, multi-cycle EX ops, load-use hazards, control-flow redirects and the halt condition. It holds a small FSM that covers redirects issued during an in-flight fetch and the terminal halt, plus two performance counters.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `IF_i_valid` in 1: the IF stage has a fetched instruction this cycle. 0 means an icache miss is in progress.
- `EX_i_busy` in 1: a multi-cycle mul/div is occupying EX.
- `EX_i_redirect` in 1: EX resolved a taken branch, jump or mispredict. The redirect is valid only when EX is not stalled.
- `ID_i_load_use` in 1: the ID instruction reads the `rd` of a load sitting in EX.
- `ME_i_busy` in 1: the dcache/LSU has not completed the MEM access.
- `WB_i_system_halt` in 1: an ebreak/halt has committed in WB.
- `FORWARD_stallIF`, `FORWARD_stallID`, `FORWARD_stallEX`, `FORWARD_stallME`, `FORWARD_stallWB` out 1 each: hold the register feeding the named stage.
- `FORWARD_flushIF`, `FORWARD_flushID`, `FORWARD_flushEX`, `FORWARD_flushME` out 1 each: load a bubble into the register after the named stage. A segment register ignores flush while its stall is set.
- `PERF_o_stall_cnt` out `CNT_W`: number of cycles in which `FORWARD_stallIF` was high.
- `PERF_o_redirect_cnt` out `CNT_W`: number of accepted redirects.

## Operation
- FSM states: `RUN`, `REDIR_WAIT`, `HALT`. Reset state is `RUN`.
- Stall/flush terms are applied by priority. Every term that is active contributes (the results are ORed), and a lower term is masked only where stated.
  1. `HALT`: all five stalls are 1 and all flushes are 0. This overrides everything else.
  2. `ME_i_busy`: stall IF, ID, EX and ME. Set `flushME` so WB receives a bubble. `stallWB` stays 0.
  3. `EX_i_busy` with no `ME_i_busy`: stall IF, ID and EX. Set `flushEX`.
  4. `ID_i_load_use` with no term 2 or 3 active: stall IF and ID. Set `flushID`.
  5. `EX_i_redirect` with no term 2 or 3 active: set `flushIF` and `flushID`. This overrides term 4's stall of ID, so the instructions behind the redirect are killed.
  6. `~IF_i_valid` with no other stall active: stall IF and set `flushIF`.
- An accepted redirect is an `EX_i_redirect` that is unmasked by terms 2 and 3 and occurs in `RUN` or `REDIR_WAIT`. An accepted redirect increments `PERF_o_redirect_cnt`.
- Transitions:
  - `RUN` → `REDIR_WAIT`: an accepted redirect arrives while `IF_i_valid` is 0, meaning a wrong-path fetch is in flight.
  - `REDIR_WAIT`: `flushIF` is forced to 1 and `stallIF` to 0. This lets the PC take the redirect target while the stale fetch is discarded.
  - `REDIR_WAIT` → `RUN`: the first cycle with `IF_i_valid` = 1 (the stale response), which is itself flushed.
  - A new accepted redirect while in `REDIR_WAIT` keeps the FSM in `REDIR_WAIT`.
  - Any state → `HALT`: `WB_i_system_halt` = 1 and `stallWB` = 0. `HALT` is terminal until reset.
- Counters: increment by 1 per qualifying cycle and wrap modulo 2^`CNT_W`. Neither counter increments in `HALT`.

## Timing
- Stall/flush outputs are combinational from the inputs and the registered state, with zero-cycle latency. State and counters update on the `posedge clk`.
- `rst` asserted at any time, including mid-stall or in `REDIR_WAIT`, has these effects:
  - The FSM goes to `RUN` and both counters go to 0 immediately.
  - While `rst` is high, all stalls are 0 and all flushes are 1.
- Simultaneous `ME_i_busy` and `EX_i_redirect`: the redirect is not accepted. EX holds it and re-presents it after MEM completes.
- Simultaneous halt and redirect: `HALT` wins on the next cycle. The redirect in the same cycle is still counted.
- Back-to-back redirects in consecutive cycles are each accepted and each counted.

## Structure
- Add the `ysyx_23060136_pipe_state_t` enum (`RUN`/`REDIR_WAIT`/`HALT`) to `ysyx_23060136_DEFINES.sv`.
- Sub-module `ysyx_23060136_perf_cnt`: a parameterized-width counter with enable and async reset, instantiated twice.
- The priority logic lives in a single `always_comb` block. The FSM and counters use `always_ff @(posedge clk or posedge rst)`.

## Test plan
- Reset for 3 cycles, then idle with all inputs 0 → all stalls and flushes are 0, state is `RUN`, counters are 0.
- `ME_i_busy` high for 4 cycles while `EX_i_redirect` = 1 → for 4 cycles stall IF/ID/EX/ME = 1, `flushME` = 1 and redirect_cnt stays 0. On the 5th cycle `flushIF` = `flushID` = 1 and redirect_cnt = 1. stall_cnt = 4.
- `ID_i_load_use` for 1 cycle → stall IF and ID, `flushID` = 1, for exactly one cycle.
- `EX_i_redirect` with `IF_i_valid` = 0, then `IF_i_valid` rises after 3 cycles → FSM is in `REDIR_WAIT` for 3 cycles with `flushIF` = 1 and `stallIF` = 0. The stale response cycle is flushed, then the FSM returns to `RUN`.
- `WB_i_system_halt` pulse, then redirects and busy inputs are applied → from the next cycle all stalls are 1, flushes are 0 and both counters are frozen.
- Force the stall counter near wrap with `CNT_W` = 4 and hold `EX_i_busy` for 17 cycles → stall_cnt = 1 after wrap. Assert `rst` mid-stall → counters are 0 immediately.
